mult_div_unit: RTL

Iterative multiply/divide unit for the MIPS execute stage. It sits directly downstream of the register file. It consumes the rs/rt read operands, computes MULT/MULTU/DIV/DIVU over 32 iterations, and holds the 64-bit result in architectural HI/LO registers. The pipeline controller uses o_busy to stall and reads HI/LO for MFHI/MFLO.

---
 rtl/mdu_pkg.sv | 22 ++
 rtl/mdu_sign_adj.sv | 16 +
 rtl/mult_div_unit.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: operation and state
// encodings, the iteration count and the LO value written on divide by zero.
package mdu_pkg;

   typedef enum logic [1:0] {
      OP_MULT  = 2'b00,
      OP_MULTU = 2'b01,
      OP_DIV   = 2'b10,
      OP_DIVU  = 2'b11
   } op_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_CALC = 2'b01,
      ST_FIX  = 2'b10,
      ST_DONE = 2'b11
   } state_t;

   localparam int          ITER_CNT = 32;
   localparam logic [31:0] DIV0_LO  = 32'hFFFF_FFFF;

endpackage

// File: rtl/mdu_sign_adj.sv
// Conditional two's-complement negate.
// Ports:
//   en   - negate din when 1, pass it through when 0
//   din  - input value, W bits
//   dout - din or -din, W bits
module mdu_sign_adj #(
   parameter int W = 32
) (
   input  logic         en,
   input  logic [W-1:0] din,
   output logic [W-1:0] dout
);

   assign dout = en ? ((~din) + W'(1)) : din;

endmodule

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// MULT/MULTU use shift-add, DIV/DIVU use restoring shift-subtract, one bit
// per cycle on operand magnitudes; signs are applied in the FIX state.
// Ports:
//   clk, rst            - clock, asynchronous active-high reset
//   i_start, i_op       - launch an operation (accepted in IDLE/DONE only)
//   i_data_rs/i_data_rt - operands A and B; i_data_rs is also the move source
//   i_mthi, i_mtlo      - write i_data_rs into HI/LO (IDLE/DONE, no start)
//   o_busy              - operation in flight (CALC or FIX)
//   o_done              - one-cycle pulse after an operation commits HI/LO
//   o_hi, o_lo          - HI/LO registers
//
// state   | meaning
// IDLE    | waiting for a command
// CALC    | iterating, counter 0..31 (one cycle only for divide by zero)
// FIX     | sign correction, HI/LO commit on exit
// DONE    | o_done pulse; a new start is accepted here too
module mult_div_unit
   import mdu_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_start,
   input  logic [1:0]        i_op,
   input  logic [DATA_W-1:0] i_data_rs,
   input  logic [DATA_W-1:0] i_data_rt,
   input  logic              i_mthi,
   input  logic              i_mtlo,
   output logic              o_busy,
   output logic              o_done,
   output logic [DATA_W-1:0] o_hi,
   output logic [DATA_W-1:0] o_lo
);

   localparam int               CNT_W    = $clog2(ITER_CNT);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER_CNT - 1);

   state_t              state, state_nx;
   op_t                 op;
   logic                accept, op_is_div, op_signed, a_neg, b_neg, rt_zero;
   logic [DATA_W-1:0]   a_mag, b_mag;
   logic [CNT_W-1:0]    cnt;
   logic [DATA_W-1:0]   hi_acc, lo_acc, opnd, hi_q, lo_q;
   logic                is_div, div0, res_neg, rem_neg;
   logic [DATA_W:0]     mul_sum, div_shift;
   logic                div_ge;
   logic [DATA_W-1:0]   div_sub;
   logic [2*DATA_W-1:0] prod_fix;
   logic [DATA_W-1:0]   quo_fix, rem_fix;

   assign op        = op_t'(i_op);
   assign op_is_div = (op == OP_DIV) || (op == OP_DIVU);
   assign op_signed = (op == OP_MULT) || (op == OP_DIV);
   assign a_neg     = op_signed & i_data_rs[DATA_W-1];
   assign b_neg     = op_signed & i_data_rt[DATA_W-1];
   assign rt_zero   = (i_data_rt == '0);
   assign accept    = i_start && ((state == ST_IDLE) || (state == ST_DONE));

   mdu_sign_adj #(.W(DATA_W)) u_abs_a (.en(a_neg), .din(i_data_rs), .dout(a_mag));
   mdu_sign_adj #(.W(DATA_W)) u_abs_b (.en(b_neg), .din(i_data_rt), .dout(b_mag));

   mdu_sign_adj #(.W(2*DATA_W)) u_fix_prod (
      .en(res_neg), .din({hi_acc, lo_acc}), .dout(prod_fix));
   mdu_sign_adj #(.W(DATA_W)) u_fix_quo (.en(res_neg), .din(lo_acc), .dout(quo_fix));
   mdu_sign_adj #(.W(DATA_W)) u_fix_rem (.en(rem_neg), .din(hi_acc), .dout(rem_fix));

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nx;
   end

   // Next state
   always_comb begin
      state_nx = state;
      case (state)
         ST_IDLE: if (i_start) state_nx = ST_CALC;
         ST_CALC: if (div0 || (cnt == CNT_LAST)) state_nx = ST_FIX;
         ST_FIX:  state_nx = ST_DONE;
         ST_DONE: state_nx = i_start ? ST_CALC : ST_IDLE;
         default: state_nx = ST_IDLE;
      endcase
   end

   // Outputs decoded from state
   always_comb begin
      o_busy = (state == ST_CALC) || (state == ST_FIX);
      o_done = (state == ST_DONE);
   end

   // Multiply step: add multiplicand when the multiplier LSB is set, then
   // shift the {hi,lo} pair right; lo fills with product bits as the
   // multiplier shifts out.
   assign mul_sum = {1'b0, hi_acc} + (lo_acc[0] ? {1'b0, opnd} : '0);

   // Restoring divide step: shift the next dividend bit into the partial
   // remainder and subtract when it fits. The difference always fits in
   // DATA_W bits when the subtraction is taken.
   assign div_shift = {hi_acc, lo_acc[DATA_W-1]};
   assign div_ge    = (div_shift >= {1'b0, opnd});
   assign div_sub   = div_shift[DATA_W-1:0] - opnd;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt     <= '0;
         hi_acc  <= '0;
         lo_acc  <= '0;
         opnd    <= '0;
         is_div  <= 1'b0;
         div0    <= 1'b0;
         res_neg <= 1'b0;
         rem_neg <= 1'b0;
         hi_q    <= '0;
         lo_q    <= '0;
      end else if (accept) begin
         cnt     <= '0;
         is_div  <= op_is_div;
         div0    <= op_is_div & rt_zero;
         res_neg <= a_neg ^ b_neg;
         rem_neg <= a_neg;
         if (op_is_div) begin
            opnd   <= b_mag;
            lo_acc <= a_mag;
            // Divide by zero parks the raw dividend here for the HI commit.
            hi_acc <= rt_zero ? i_data_rs : '0;
         end else begin
            opnd   <= a_mag;
            lo_acc <= b_mag;
            hi_acc <= '0;
         end
      end else if (state == ST_CALC) begin
         cnt <= cnt + CNT_W'(1);
         if (!div0) begin
            if (is_div) begin
               hi_acc <= div_ge ? div_sub : div_shift[DATA_W-1:0];
               lo_acc <= {lo_acc[DATA_W-2:0], div_ge};
            end else begin
               hi_acc <= mul_sum[DATA_W:1];
               lo_acc <= {mul_sum[0], lo_acc[DATA_W-1:1]};
            end
         end
      end else if (state == ST_FIX) begin
         if (!is_div) begin
            {hi_q, lo_q} <= prod_fix;
         end else if (div0) begin
            hi_q <= hi_acc;
            lo_q <= DIV0_LO;
         end else begin
            hi_q <= rem_fix;
            lo_q <= quo_fix;
         end
      end else begin
         // IDLE or DONE without a start: moves take effect.
         if (i_mthi) hi_q <= i_data_rs;
         if (i_mtlo) lo_q <= i_data_rs;
      end
   end

   assign o_hi = hi_q;
   assign o_lo = lo_q;

endmodule
